uart_tx_sched: RTL

- Sequencer between the TX FIFO and the UART transmitter core.
- Pops one byte at a time from the FIFO and launches a frame on the transmitter.
- Waits for frame completion, then enforces a programmable inter-frame gap.
- Guards against a hung transmitter with a watchdog; reports frame count and a sticky timeout flag.

---
 rtl/uart_ctrl_pkg.sv | 22 ++
 rtl/uart_sync2.sv | 23 ++
 rtl/uart_tx_sched.sv | 113 +++++++++++
 3 files changed

// File: rtl/uart_ctrl_pkg.sv
// Shared types and default sizes for the UART TX scheduler.
package uart_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      START,
      WAIT_DONE,
      GAP
   } tx_sched_state_e;

   localparam int SIZE_DATA_DEF   = 8;
   localparam int GAP_W_DEF       = 8;
   localparam int TIMEOUT_CYC_DEF = 200000;
   localparam int CNT_W_DEF       = 16;

   // Watchdog width; never below 1 bit so tiny timeouts still elaborate.
   function automatic int wd_width(input int cyc);
      return (cyc > 2) ? $clog2(cyc) : 1;
   endfunction

endpackage

// File: rtl/uart_sync2.sv
// Generic two-flop synchronizer with a configurable reset value.
module uart_sync2 #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_d,
   output logic o_q
);

   logic meta;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         meta <= RST_VAL;
         o_q  <= RST_VAL;
      end else begin
         meta <= i_d;
         o_q  <= meta;
      end
   end

endmodule

// File: rtl/uart_tx_sched.sv
// Pops bytes from the TX FIFO, launches frames, enforces an inter-frame gap
// and a watchdog. Optional CTS gating is enabled by defining UART_TX_CTS_EN.
module uart_tx_sched
   import uart_ctrl_pkg::*;
#(
   parameter int SIZE_DATA   = SIZE_DATA_DEF,
   parameter int GAP_W       = GAP_W_DEF,
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
   parameter int CNT_W       = CNT_W_DEF
) (
`ifdef UART_TX_CTS_EN
   input  logic                 i_cts_n,
`endif
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_en,
   input  logic [GAP_W-1:0]     i_gap,
   input  logic                 i_clr_err,
   input  logic                 i_fifo_empty,
   input  logic [SIZE_DATA-1:0] i_fifo_data,
   output logic                 o_fifo_rd_en,
   output logic                 o_tx_start,
   output logic [SIZE_DATA-1:0] o_tx_data,
   input  logic                 i_tx_done,
   output logic                 o_busy,
   output logic [CNT_W-1:0]     o_tx_count,
   output logic                 o_timeout
);

   localparam int WD_W = wd_width(TIMEOUT_CYC);
   localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYC - 1);

   tx_sched_state_e state, state_nxt;
   logic [WD_W-1:0]  wd;
   logic [GAP_W-1:0] gap_cnt;
   logic             cts_ok;
   logic             wd_max;
   logic             to_set;

`ifdef UART_TX_CTS_EN
   logic cts_n_sync;

   // Reset to "not clear" so nothing is sent until the peer asserts CTS.
   uart_sync2 #(.RST_VAL(1'b1)) u_cts_sync (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_d     (i_cts_n),
      .o_q     (cts_n_sync)
   );
   assign cts_ok = ~cts_n_sync;
`else
   assign cts_ok = 1'b1;
`endif

   assign wd_max = (wd == WD_MAX);
   // Done takes priority over a coincident timeout.
   assign to_set = (state == WAIT_DONE) && !i_tx_done && wd_max;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      if (i_en && !i_fifo_empty && cts_ok) state_nxt = FETCH;
         FETCH:     state_nxt = i_fifo_empty ? IDLE : START;
         START:     state_nxt = WAIT_DONE;
         WAIT_DONE: begin
            if (i_tx_done)   state_nxt = (i_gap == '0) ? IDLE : GAP;
            else if (wd_max) state_nxt = IDLE;
         end
         GAP:       if (gap_cnt == GAP_W'(1)) state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_tx_data  <= '0;
         o_tx_count <= '0;
         wd         <= '0;
         gap_cnt    <= '0;
      end else begin
         case (state)
            FETCH:     if (!i_fifo_empty) o_tx_data <= i_fifo_data;
            START:     wd <= '0;
            WAIT_DONE: begin
               if (i_tx_done) begin
                  o_tx_count <= o_tx_count + 1'b1;
                  gap_cnt    <= i_gap;
               end else if (!wd_max) begin
                  wd <= wd + 1'b1;
               end
            end
            GAP:       gap_cnt <= gap_cnt - 1'b1;
            default:   ;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)       o_timeout <= 1'b0;
      else if (to_set)    o_timeout <= 1'b1;
      else if (i_clr_err) o_timeout <= 1'b0;
   end

   assign o_fifo_rd_en = (state == FETCH);
   assign o_tx_start   = (state == START);
   assign o_busy       = (state != IDLE);

endmodule
